apb_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that lets NUM_REQ independent requesters share the single APB master wrapper's request port.
- Accepts one request at a time over a valid/ready handshake.
- Drives transfer, READ_WRITE, the address buses and write data into the wrapper, and holds them stable until the wrapper signals completion.
- Returns read data and PSLVERR to the granted requester.
- A watchdog aborts transfers that never complete.

---
 rtl/apb_req_arbiter_if.sv | 42 ++++
 rtl/apb_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Request/response and APB-wrapper signal bundle for apb_req_arbiter.
// master = arbiter side, slave = requesters plus wrapper/integration side.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;
  logic                      transfer;
  logic                      READ_WRITE;
  logic [ADDR_W-1:0]         apb_write_paddr;
  logic [ADDR_W-1:0]         apb_read_paddr;
  logic [DATA_W-1:0]         apb_write_data;
  logic                      xfer_done;
  logic                      PSLVERR;
  logic [DATA_W-1:0]         apb_read_data_out;
  logic                      busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
           xfer_done, PSLVERR, apb_read_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           transfer, READ_WRITE, apb_write_paddr, apb_read_paddr,
           apb_write_data, busy
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
           xfer_done, PSLVERR, apb_read_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           transfer, READ_WRITE, apb_write_paddr, apb_read_paddr,
           apb_write_data, busy
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master wrapper among NUM_REQ
// requesters, with a watchdog that aborts transfers which never complete.
module apb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_req_arbiter_if.master bus
);

  localparam int          GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       cur;
  logic                cur_write;
  logic [CW-1:0]       cnt;

  logic                transfer_r;
  logic                rw_r;
  logic [ADDR_W-1:0]   wpaddr_r;
  logic [ADDR_W-1:0]   rpaddr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [NUM_REQ-1:0]  rsp_valid_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_slverr_r;
  logic                rsp_timeout_r;

  logic                any_valid;
  logic [GW-1:0]       pick;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [NUM_REQ-1:0]  cur_oh;
  logic                pick_write;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  // Scan starts just after the last grant so it has lowest priority next time.
  always_comb begin
    int unsigned idx;
    logic        found;
    found     = 1'b0;
    pick      = '0;
    idx       = 0;
    any_valid = |bus.req_valid;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= NR) idx = idx - NR;
      if (!found && bus.req_valid[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
    cur_oh        = '0;
    cur_oh[cur]   = 1'b1;
    pick_write    = bus.req_write[pick];
    pick_addr     = bus.req_addr[pick*ADDR_W +: ADDR_W];
    pick_wdata    = bus.req_wdata[pick*DATA_W +: DATA_W];
  end

  assign bus.req_ready       = (state == IDLE && any_valid) ? pick_oh : '0;
  assign bus.busy            = (state != IDLE);
  assign bus.transfer        = transfer_r;
  assign bus.READ_WRITE      = rw_r;
  assign bus.apb_write_paddr = wpaddr_r;
  assign bus.apb_read_paddr  = rpaddr_r;
  assign bus.apb_write_data  = wdata_r;
  assign bus.rsp_valid       = rsp_valid_r;
  assign bus.rsp_rdata       = rsp_rdata_r;
  assign bus.rsp_slverr      = rsp_slverr_r;
  assign bus.rsp_timeout     = rsp_timeout_r;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      last_grant    <= GW'(NUM_REQ - 1);
      cur           <= '0;
      cur_write     <= 1'b0;
      cnt           <= '0;
      transfer_r    <= 1'b0;
      rw_r          <= 1'b0;
      wpaddr_r      <= '0;
      rpaddr_r      <= '0;
      wdata_r       <= '0;
      rsp_valid_r   <= '0;
      rsp_rdata_r   <= '0;
      rsp_slverr_r  <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      rsp_valid_r   <= '0;
      rsp_rdata_r   <= '0;
      rsp_slverr_r  <= 1'b0;
      rsp_timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            cur        <= pick;
            cur_write  <= pick_write;
            transfer_r <= 1'b1;
            rw_r       <= pick_write;
            wpaddr_r   <= pick_write ? pick_addr  : '0;
            rpaddr_r   <= pick_write ? '0 : pick_addr;
            wdata_r    <= pick_write ? pick_wdata : '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Completion wins over the watchdog when both land in the same cycle.
          if (bus.xfer_done || cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid_r   <= cur_oh;
            rsp_rdata_r   <= (bus.xfer_done && !cur_write) ? bus.apb_read_data_out : '0;
            rsp_slverr_r  <= bus.xfer_done ? bus.PSLVERR : 1'b1;
            rsp_timeout_r <= !bus.xfer_done;
            transfer_r    <= 1'b0;
            rw_r          <= 1'b0;
            wpaddr_r      <= '0;
            rpaddr_r      <= '0;
            wdata_r       <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last_grant <= cur;
          cnt        <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized self-checking bench for apb_req_arbiter against a transaction-level
// round-robin model.
module tb_apb_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 64;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int model_last = N - 1;

  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_wdata [N];
  logic [N-1:0]  p_write;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the previous grant, wrapping.
  function automatic int model_pick(input logic [N-1:0] v);
    logic [N-1:0] sh;
    for (int i = 1; i <= N; i++) begin
      sh = v >> ((model_last + i) % N);
      if (sh[0]) return (model_last + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int g);
    logic [63:0] r;
    r = 64'd1 << g;
    return r;
  endfunction

  function automatic logic [63:0] bus_vec();
    return {36'b0, bus.transfer, bus.READ_WRITE, bus.apb_write_paddr,
            bus.apb_read_paddr, bus.apb_write_data};
  endfunction

  function automatic logic [63:0] exp_bus(input logic w, input logic [AW-1:0] a,
                                          input logic [DW-1:0] d);
    return {36'b0, 1'b1, w, (w ? a : AW'(0)), (w ? AW'(0) : a), (w ? d : DW'(0))};
  endfunction

  task automatic drive_payload();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = p_addr[i];
      bus.req_wdata[i*DW +: DW] = p_wdata[i];
    end
    bus.req_write = p_write;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++) begin
      p_addr[i]  = AW'($urandom);
      p_wdata[i] = DW'($urandom);
    end
    p_write = N'($urandom);
  endtask

  // wait_k: WAIT-cycle index carrying xfer_done; outside 0..TO-1 means never.
  task automatic run_txn(input logic [N-1:0] vmask, input int wait_k,
                         input logic [DW-1:0] rd, input logic err, input logic spurious);
    int          g;
    int          last_w;
    logic        to;
    logic        w;
    logic [63:0] ev;
    @(negedge PCLK);
    drive_payload();
    bus.req_valid = vmask;
    bus.xfer_done = 1'b0;
    #1;
    g = model_pick(vmask);
    check("req_ready", 64'(bus.req_ready), onehot(g));
    check("busy_idle", 64'(bus.busy), 64'd0);
    w  = p_write[g];
    ev = exp_bus(w, p_addr[g], p_wdata[g]);
    @(negedge PCLK);
    bus.req_valid = '0;
    bus.xfer_done = spurious;
    #1;
    check("issue_bus", bus_vec(), ev);
    check("ready_off", 64'(bus.req_ready), 64'd0);
    check("busy_xfer", 64'(bus.busy), 64'd1);
    to     = !(wait_k >= 0 && wait_k <= TO - 1);
    last_w = to ? TO - 1 : wait_k;
    for (int wc = 0; wc <= last_w; wc++) begin
      @(negedge PCLK);
      bus.xfer_done         = (wc == wait_k);
      bus.apb_read_data_out = (wc == wait_k) ? rd  : DW'($urandom);
      bus.PSLVERR           = (wc == wait_k) ? err : 1'($urandom);
      #1;
      check("wait_bus", bus_vec(), ev);
      check("wait_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    @(negedge PCLK);
    bus.xfer_done = 1'b0;
    #1;
    check("rsp_valid",   64'(bus.rsp_valid), onehot(g));
    check("rsp_rdata",   64'(bus.rsp_rdata), (to || w) ? 64'd0 : 64'(rd));
    check("rsp_slverr",  64'(bus.rsp_slverr), to ? 64'd1 : 64'(err));
    check("rsp_timeout", 64'(bus.rsp_timeout), 64'(to));
    check("rsp_bus",     bus_vec(), 64'd0);
    model_last = g;
  endtask

  initial begin
    logic [N-1:0] vm;
    int           wk;
    bus.req_valid         = '0;
    bus.req_write         = '0;
    bus.req_addr          = '0;
    bus.req_wdata         = '0;
    bus.xfer_done         = 1'b0;
    bus.PSLVERR           = 1'b0;
    bus.apb_read_data_out = '0;
    randomize_payload();

    @(negedge PCLK);
    #1;
    check("rst_bus",   bus_vec(), 64'd0);
    check("rst_busy",  64'(bus.busy), 64'd0);
    check("rst_rsp",   64'(bus.rsp_valid), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // xfer_done while idle must not start anything
    @(negedge PCLK);
    bus.xfer_done = 1'b1;
    @(negedge PCLK);
    bus.xfer_done = 1'b0;
    #1;
    check("idle_done_busy", 64'(bus.busy), 64'd0);
    check("idle_done_rsp",  64'(bus.rsp_valid), 64'd0);

    // single write from req0
    p_addr[0] = 9'h155; p_wdata[0] = 8'hA5; p_write = 4'b0001;
    run_txn(4'b0001, 1, 8'h00, 1'b0, 1'b0);

    // single read from req2 with slave error
    p_addr[2] = 9'h0FF; p_write = 4'b0000;
    run_txn(4'b0100, 1, 8'h3C, 1'b1, 1'b0);

    // fairness with all requesters valid; model_last restarts round at 3
    model_last = N - 1;
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      randomize_payload();
      run_txn(4'b1111, 0, DW'($urandom), 1'b0, 1'b0);
    end

    // watchdog abort, then a normal transfer
    randomize_payload();
    run_txn(4'b0010, -1, 8'h77, 1'b0, 1'b0);
    randomize_payload();
    run_txn(4'b0110, 2, 8'h5A, 1'b0, 1'b1);
    // xfer_done in the last watchdog cycle completes normally
    randomize_payload();
    run_txn(4'b1001, TO - 1, 8'hC3, 1'b0, 1'b0);

    // reset during WAIT of a read
    randomize_payload();
    p_write = 4'b0000;
    @(negedge PCLK);
    drive_payload();
    bus.req_valid = 4'b1000;
    @(negedge PCLK);
    bus.req_valid = '0;
    @(negedge PCLK);
    @(negedge PCLK);
    #1;
    check("pre_rst_xfer", 64'(bus.transfer), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_bus",  bus_vec(), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_rsp",  64'(bus.rsp_valid), 64'd0);
    @(negedge PCLK);
    PRESETn    = 1'b1;
    model_last = N - 1;
    bus.xfer_done = 1'b1;
    @(negedge PCLK);
    bus.xfer_done = 1'b0;
    #1;
    check("post_rst_rsp", 64'(bus.rsp_valid), 64'd0);
    randomize_payload();
    run_txn(4'b1111, 1, 8'h11, 1'b0, 1'b0);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      randomize_payload();
      vm = N'($urandom_range(1, (1 << N) - 1));
      wk = ($urandom_range(0, 19) == 0) ? TO - 1 : int'($urandom_range(0, 4));
      run_txn(vm, wk, DW'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog got timeout exp finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule
